// File: rtl/cache_bus_ctrl_if.sv
// Cache-side line bus plus memory beat bus for cache_bus_ctrl.
// slave: the controller. master: the cache/memory environment driving it.
interface cache_bus_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned BEAT_W = 32
);
  logic              BUS_EN;
  logic              BUS_WR;
  logic [ADDR_W-1:0] BUS_ADDR;
  logic [LINE_W-1:0] BUS_WRITE;
  logic              BUS_R;
  logic [LINE_W-1:0] BUS_READ;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [BEAT_W-1:0] mem_rdata;

  modport slave (
    input  BUS_EN, BUS_WR, BUS_ADDR, BUS_WRITE, mem_ack, mem_rdata,
    output BUS_R, BUS_READ, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output BUS_EN, BUS_WR, BUS_ADDR, BUS_WRITE, mem_ack, mem_rdata,
    input  BUS_R, BUS_READ, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_bus_ctrl.sv
// Cache line bus controller: splits each 128-bit line fill/writeback into four
// 32-bit memory beats on a req/ack handshake, and presents a single 4-phase
// line handshake (BUS_EN/BUS_R) to the cache.
// Optional feature: define MEM_TIMEOUT_EN to add the ack watchdog and bus_err.
module cache_bus_ctrl #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned LINE_W         = 128,
  parameter int unsigned BEAT_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            clr,
  cache_bus_ctrl_if.slave bus,
  output logic            busy
`ifdef MEM_TIMEOUT_EN
  ,
  output logic            bus_err
`endif
);

  localparam int unsigned NumBeats = LINE_W / BEAT_W;

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [ADDR_W-5:0] line_q, line_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // Next-state and datapath updates for the line transfer FSM.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.BUS_EN) begin
          line_d  = bus.BUS_ADDR[ADDR_W-1:4];
          wr_d    = bus.BUS_WR;
          wdata_d = bus.BUS_WRITE;
          beat_d  = 2'd0;
          state_d = StXfer;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      StXfer: begin
        if (bus.mem_ack) begin
          if (!wr_q) rdata_d[BEAT_W*beat_q +: BEAT_W] = bus.mem_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'(NumBeats - 1)) state_d = StDone;
`ifdef MEM_TIMEOUT_EN
          cnt_d = '0;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog fired: unreceived fill lanes read back as all ones.
          if (!wr_q) begin
            for (int i = 0; i < int'(NumBeats); i++) begin
              if (2'(i) >= beat_q) rdata_d[BEAT_W*i +: BEAT_W] = '1;
            end
          end
          beat_d  = 2'd0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDone: begin
        if (!bus.BUS_EN) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; async reset abandons any transfer.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      beat_q  <= 2'd0;
      line_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Outputs decode straight from registers so reset clears them immediately.
  always_comb begin
    bus.BUS_R     = (state_q == StDone);
    bus.BUS_READ  = rdata_q;
    bus.mem_req   = (state_q == StXfer);
    bus.mem_we    = (state_q == StXfer) && wr_q;
    bus.mem_addr  = {line_q, beat_q, 2'b00};
    bus.mem_wdata = wdata_q[BEAT_W*beat_q +: BEAT_W];
    busy          = (state_q != StIdle);
`ifdef MEM_TIMEOUT_EN
    bus_err       = err_q;
`endif
  end

endmodule
